// File: rtl/tpu_pkg.sv
// Shared TPU control-word constants and the sequencer state encoding.
package tpu_pkg;

    localparam int INSTR_W = 156;
    localparam int DEPTH   = 64;
    localparam int DELAY_W = 8;

    localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } seq_state_t;

endpackage

// File: rtl/instr_mem.sv
// Program store: DEPTH entries of {instruction, delay}, one synchronous write
// port and one combinational read port. The array is intentionally not reset.
module instr_mem #(
    parameter int WIDTH = 164,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/instruction_sequencer.sv
// Issues a preloaded program to the instruction decoder, one entry per step,
// with a programmable run of NOP cycles after each issued entry.
//
//  state | meaning
//  IDLE  | no program running, output NOP, waiting for start
//  ISSUE | register mem[pc] onto the instruction bus (held off by pause)
//  WAIT  | NOP cycles after an entry, counting down its delay
//  DONE  | program finished, pulse done and return to IDLE
module instruction_sequencer
    import tpu_pkg::*;
#(
    parameter int INSTR_W = tpu_pkg::INSTR_W,
    parameter int DEPTH   = tpu_pkg::DEPTH,
    parameter int AW      = $clog2(DEPTH),
    parameter int DELAY_W = tpu_pkg::DELAY_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               prog_wr_en,
    input  logic [AW-1:0]      prog_wr_addr,
    input  logic [INSTR_W-1:0] prog_wr_instr,
    input  logic [DELAY_W-1:0] prog_wr_delay,
    input  logic [AW-1:0]      prog_last_addr,
    input  logic               start,
    input  logic               pause,
    input  logic               abort,
    output logic [INSTR_W-1:0] instruction_out,
    output logic               instr_valid,
    output logic [AW-1:0]      pc_out,
    output logic               busy,
    output logic               done
);

    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_ISSUE = ISSUE;
    localparam logic [1:0] S_WAIT  = WAIT;
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]                 state;
    logic [AW-1:0]              pc;
    logic [AW-1:0]              last_addr;
    logic [DELAY_W-1:0]         cnt;
    logic [INSTR_W+DELAY_W-1:0] rd_word;
    logic [INSTR_W-1:0]         rd_instr;
    logic [DELAY_W-1:0]         rd_delay;
    logic                       pc_is_last;

    assign busy       = (state != S_IDLE);
    assign pc_is_last = (pc == last_addr);
    assign {rd_instr, rd_delay} = rd_word;

    // The running program is protected: host writes only land while idle.
    instr_mem #(
        .WIDTH (INSTR_W + DELAY_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_instr_mem (
        .clk     (clk),
        .wr_en   (prog_wr_en && !busy),
        .wr_addr (prog_wr_addr),
        .wr_data ({prog_wr_instr, prog_wr_delay}),
        .rd_addr (pc),
        .rd_data (rd_word)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= S_IDLE;
            pc              <= '0;
            last_addr       <= '0;
            cnt             <= '0;
            instruction_out <= '0;
            instr_valid     <= 1'b0;
            pc_out          <= '0;
            done            <= 1'b0;
        end else begin
            instruction_out <= INSTR_W'(NOP_INSTR);
            instr_valid     <= 1'b0;
            done            <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !abort) begin
                        last_addr <= prog_last_addr;
                        pc        <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (!pause) begin
                        instruction_out <= rd_instr;
                        instr_valid     <= 1'b1;
                        pc_out          <= pc;
                        if (rd_delay != '0) begin
                            cnt   <= rd_delay;
                            state <= S_WAIT;
                        end else if (pc_is_last) begin
                            state <= S_DONE;
                        end else begin
                            pc <= pc + AW'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        state <= S_IDLE;
                    end else if (!pause) begin
                        cnt <= cnt - DELAY_W'(1);
                        // Terminal count: this decrement is the last NOP cycle.
                        if (cnt == DELAY_W'(1)) begin
                            if (pc_is_last) begin
                                state <= S_DONE;
                            end else begin
                                pc    <= pc + AW'(1);
                                state <= S_ISSUE;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (!abort) begin
                        done <= 1'b1;
                    end
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenario table,
// hand-written corner sequences and randomized programs against a script model.
module tb_instruction_sequencer;

    localparam int IW  = 156;
    localparam int DEP = 64;
    localparam int AWL = 6;
    localparam int DW  = 8;
    localparam int PKW = 3 + AWL + IW;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           prog_wr_en = 1'b0;
    logic [AWL-1:0] prog_wr_addr = '0;
    logic [IW-1:0]  prog_wr_instr = '0;
    logic [DW-1:0]  prog_wr_delay = '0;
    logic [AWL-1:0] prog_last_addr = '0;
    logic           start = 1'b0;
    logic           pause = 1'b0;
    logic           abort = 1'b0;
    logic [IW-1:0]  instruction_out;
    logic           instr_valid;
    logic [AWL-1:0] pc_out;
    logic           busy;
    logic           done;

    instruction_sequencer #(
        .INSTR_W (IW),
        .DEPTH   (DEP),
        .AW      (AWL),
        .DELAY_W (DW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .prog_wr_en      (prog_wr_en),
        .prog_wr_addr    (prog_wr_addr),
        .prog_wr_instr   (prog_wr_instr),
        .prog_wr_delay   (prog_wr_delay),
        .prog_last_addr  (prog_last_addr),
        .start           (start),
        .pause           (pause),
        .abort           (abort),
        .instruction_out (instruction_out),
        .instr_valid     (instr_valid),
        .pc_out          (pc_out),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    logic [IW-1:0] ref_instr [DEP];
    int            ref_delay [DEP];
    int            exp_pc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    typedef struct {
        int last;
        int d0;
        int d1;
        int d2;
        int pause_at;
        int pause_len;
        int exp_issues;
        int exp_nops;
        int exp_lat;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [IW-1:0] rand_instr();
        logic [159:0] t;
        t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        t[0] = 1'b1;
        return t[IW-1:0];
    endfunction

    function automatic logic [PKW-1:0] pk(input bit b, input bit dn, input bit v,
                                          input int pc, input logic [IW-1:0] ins);
        logic [AWL-1:0] p;
        p = pc[AWL-1:0];
        return {b, dn, v, p, ins};
    endfunction

    task automatic check(input string name, input logic [PKW-1:0] exp);
        logic [PKW-1:0] act;
        act = {busy, done, instr_valid, pc_out, instruction_out};
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {busy,done,valid,pc,instr}=%h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int addr, input logic [IW-1:0] ins, input int d);
        prog_wr_en    = 1'b1;
        prog_wr_addr  = addr[AWL-1:0];
        prog_wr_instr = ins;
        prog_wr_delay = d[DW-1:0];
        tick();
        prog_wr_en    = 1'b0;
        ref_instr[addr] = ins;
        ref_delay[addr] = d;
    endtask

    task automatic start_prog(input int last);
        prog_last_addr = last[AWL-1:0];
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start", pk(1, 0, 0, exp_pc, '0));
    endtask

    // Reference: the program is a script of steps (issue k, D nops, done);
    // each unpaused cycle consumes one step, a paused cycle yields a NOP,
    // and the done step is never held off by pause.
    task automatic run_model(input int last, input int pause_pct, input int wr_at,
                             input int start_at, input string tag);
        int script[$];
        int cyc;
        int step;
        bit p;
        logic [PKW-1:0] e;
        for (int i = 0; i <= last; i++) begin
            script.push_back(i);
            for (int k = 0; k < ref_delay[i]; k++) script.push_back(-1);
        end
        script.push_back(-2);
        start_prog(last);
        cyc = 0;
        while (script.size() > 0 && cyc < 3000) begin
            cyc++;
            p = ($urandom_range(99) < pause_pct);
            pause = p;
            start = (cyc == start_at);
            if (cyc == wr_at) begin
                prog_wr_en    = 1'b1;
                prog_wr_addr  = 6'd1;
                prog_wr_instr = ~ref_instr[1];
                prog_wr_delay = 8'd7;
            end
            tick();
            pause = 1'b0;
            start = 1'b0;
            prog_wr_en = 1'b0;
            step = script[0];
            if (step == -2) begin
                void'(script.pop_front());
                e = pk(0, 1, 0, exp_pc, '0);
            end else if (p) begin
                e = pk(1, 0, 0, exp_pc, '0);
            end else begin
                void'(script.pop_front());
                if (step >= 0) begin
                    exp_pc = step;
                    e = pk(1, 0, 1, step, ref_instr[step]);
                end else begin
                    e = pk(1, 0, 0, exp_pc, '0);
                end
            end
            check(tag, e);
        end
        if (script.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: %0d steps left, required 0", tag, script.size());
        end
        tick();
        check({tag, "_idle"}, pk(0, 0, 0, exp_pc, '0));
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int dl[3];
        int issues;
        int nops;
        int lat;
        dl[0] = v.d0; dl[1] = v.d1; dl[2] = v.d2;
        for (int i = 0; i <= v.last; i++) write_entry(i, rand_instr(), dl[i]);
        start_prog(v.last);
        issues = 0; nops = 0; lat = -1;
        for (int j = 1; j <= 60; j++) begin
            pause = (j >= v.pause_at && j < v.pause_at + v.pause_len);
            tick();
            pause = 1'b0;
            if (instr_valid) begin
                if (issues <= v.last)
                    check($sformatf("vec%0d_issue%0d", idx, issues),
                          pk(1, 0, 1, issues, ref_instr[issues]));
                issues++;
            end else if (done) begin
                lat = j;
                break;
            end else begin
                nops++;
            end
        end
        exp_pc = v.last;
        check_int($sformatf("vec%0d_issues", idx), issues, v.exp_issues);
        check_int($sformatf("vec%0d_nops", idx), nops, v.exp_nops);
        check_int($sformatf("vec%0d_done_latency", idx), lat, v.exp_lat);
        tick();
    endtask

    vec_t vecs [6];

    initial begin
        vecs = '{
            '{2, 0, 0, 0, 0, 0, 3, 0, 4},
            '{1, 3, 0, 0, 0, 0, 2, 3, 6},
            '{1, 2, 0, 0, 3, 4, 2, 6, 9},
            '{0, 0, 0, 0, 0, 0, 1, 0, 2},
            '{2, 1, 0, 2, 1, 2, 3, 5, 9},
            '{2, 0, 0, 0, 2, 3, 3, 3, 7}
        };

        #12;
        check("reset", pk(0, 0, 0, 0, '0));
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

        // start together with abort in IDLE is ignored
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", pk(0, 0, 0, exp_pc, '0));

        // abort after the second of five issues, then restart from entry 0
        for (int i = 0; i < 5; i++) write_entry(i, rand_instr(), 0);
        start_prog(4);
        tick();
        check("abort_issue0", pk(1, 0, 1, 0, ref_instr[0]));
        tick();
        check("abort_issue1", pk(1, 0, 1, 1, ref_instr[1]));
        exp_pc = 1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_edge", pk(0, 0, 0, 1, '0));
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_no_done", pk(0, 0, 0, 1, '0));
        end
        run_model(4, 0, -1, -1, "abort_restart");

        // host write to entry 1 while busy must be dropped
        write_entry(0, rand_instr(), 4);
        write_entry(1, rand_instr(), 0);
        write_entry(2, rand_instr(), 0);
        run_model(2, 0, 2, -1, "wr_busy");
        run_model(2, 0, -1, -1, "wr_after_idle");

        // asynchronous reset mid-WAIT
        write_entry(0, rand_instr(), 5);
        start_prog(0);
        tick();
        check("rst_issue", pk(1, 0, 1, 0, ref_instr[0]));
        tick();
        #3 rst = 1'b1;
        #1 check("async_rst", pk(0, 0, 0, 0, '0));
        exp_pc = 0;
        #1 rst = 1'b0;
        tick();
        run_model(0, 0, -1, -1, "after_rst");

        // full depth, with a start pulse while busy
        for (int i = 0; i < DEP; i++) write_entry(i, rand_instr(), 0);
        run_model(DEP - 1, 0, -1, 5, "full_depth");

        for (int r = 0; r < 6; r++) begin
            int last;
            last = $urandom_range(7);
            for (int i = 0; i <= last; i++) write_entry(i, rand_instr(), $urandom_range(3));
            run_model(last, 30, -1, -1, $sformatf("random%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
